// File: rtl/cordic_scheduler_if.sv
// Bundle of the requester, shared-stage and result signals around the
// CORDIC scheduler. The scheduler takes the slave view; whatever surrounds
// it (requesters, the stage, the result consumer) takes the master view.
interface cordic_scheduler_if #(
  parameter int DATA_W = 16
);
  logic              r0_valid;
  logic              r0_ready;
  logic [DATA_W-1:0] r0_x;
  logic [DATA_W-1:0] r0_y;
  logic [DATA_W-1:0] r0_z;
  logic              r0_mode;

  logic              r1_valid;
  logic              r1_ready;
  logic [DATA_W-1:0] r1_x;
  logic [DATA_W-1:0] r1_y;
  logic [DATA_W-1:0] r1_z;
  logic              r1_mode;

  logic [DATA_W-1:0] st_x;
  logic [DATA_W-1:0] st_y;
  logic [DATA_W-1:0] st_z;
  logic              st_mode;
  logic [2:0]        st_stage;
  logic [DATA_W-1:0] st_x_out;
  logic [DATA_W-1:0] st_y_out;
  logic [DATA_W-1:0] st_z_out;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_x;
  logic [DATA_W-1:0] out_y;
  logic [DATA_W-1:0] out_z;
  logic              out_mode;
  logic              out_id;

  modport slave (
    input  r0_valid, r0_x, r0_y, r0_z, r0_mode,
    output r0_ready,
    input  r1_valid, r1_x, r1_y, r1_z, r1_mode,
    output r1_ready,
    output st_x, st_y, st_z, st_mode, st_stage,
    input  st_x_out, st_y_out, st_z_out,
    output out_valid, out_x, out_y, out_z, out_mode, out_id,
    input  out_ready
  );

  modport master (
    output r0_valid, r0_x, r0_y, r0_z, r0_mode,
    input  r0_ready,
    output r1_valid, r1_x, r1_y, r1_z, r1_mode,
    input  r1_ready,
    input  st_x, st_y, st_z, st_mode, st_stage,
    output st_x_out, st_y_out, st_z_out,
    input  out_valid, out_x, out_y, out_z, out_mode, out_id,
    output out_ready
  );
endinterface

// File: rtl/cordic_scheduler.sv
// Time-shares one registered CORDIC stage between two requesters. A job is
// accepted from the round-robin winner, walked through N_ITER stage passes
// (issue one cycle, capture the stage result the next) and then held as a
// result until the consumer takes it. Operands pass through untouched.
module cordic_scheduler #(
  parameter int N_ITER = 8
) (
  input logic               clock,
  input logic               reset,
  cordic_scheduler_if.slave bus
);

  localparam int         DATA_W = 16;
  localparam logic [2:0] K_LAST = 3'(N_ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        k;
  logic [2:0]        k_nxt;
  logic              last_srv;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic [DATA_W-1:0] sel_x;
  logic [DATA_W-1:0] sel_y;
  logic [DATA_W-1:0] sel_z;
  logic              sel_mode;
  logic [DATA_W-1:0] wx;
  logic [DATA_W-1:0] wy;
  logic [DATA_W-1:0] wz;
  logic              wmode;
  logic              wid;
  logic [DATA_W-1:0] st_x_q;
  logic [DATA_W-1:0] st_y_q;
  logic [DATA_W-1:0] st_z_q;
  logic              st_mode_q;
  logic [2:0]        st_stage_q;

  // Round-robin grant: only in IDLE and never while reset is asserted; with
  // both requesters waiting, the one that was not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.r0_valid && (!bus.r1_valid || last_srv)) begin
        gnt0 = 1'b1;
      end else if (bus.r1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign bus.r0_ready = gnt0;
  assign bus.r1_ready = gnt1;
  assign accept       = gnt0 | gnt1;

  // Operand mux for the granted requester.
  always_comb begin
    sel_x    = bus.r0_x;
    sel_y    = bus.r0_y;
    sel_z    = bus.r0_z;
    sel_mode = bus.r0_mode;
    if (gnt1) begin
      sel_x    = bus.r1_x;
      sel_y    = bus.r1_y;
      sel_z    = bus.r1_z;
      sel_mode = bus.r1_mode;
    end
  end

  // Next-state and iteration counter logic.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ISSUE;
          k_nxt     = 3'd0;
        end
      end
      ISSUE: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (k == K_LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ISSUE;
          k_nxt     = k + 3'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and iteration counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      k     <= 3'd0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Last-served pointer; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_srv <= 1'b1;
    end else if (gnt0) begin
      last_srv <= 1'b0;
    end else if (gnt1) begin
      last_srv <= 1'b1;
    end
  end

  // Working registers: loaded on accept, refreshed from the stage on capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      wx    <= '0;
      wy    <= '0;
      wz    <= '0;
      wmode <= 1'b0;
      wid   <= 1'b0;
    end else if (accept) begin
      wx    <= sel_x;
      wy    <= sel_y;
      wz    <= sel_z;
      wmode <= sel_mode;
      wid   <= gnt1;
    end else if (state == CAPTURE) begin
      wx <= bus.st_x_out;
      wy <= bus.st_y_out;
      wz <= bus.st_z_out;
    end
  end

  // Stage drive registers: updated only on entry to ISSUE so that during
  // ISSUE they mirror the working registers and k, and hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_x_q     <= '0;
      st_y_q     <= '0;
      st_z_q     <= '0;
      st_mode_q  <= 1'b0;
      st_stage_q <= 3'd0;
    end else if (accept) begin
      st_x_q     <= sel_x;
      st_y_q     <= sel_y;
      st_z_q     <= sel_z;
      st_mode_q  <= sel_mode;
      st_stage_q <= 3'd0;
    end else if (state == CAPTURE && k != K_LAST) begin
      st_x_q     <= bus.st_x_out;
      st_y_q     <= bus.st_y_out;
      st_z_q     <= bus.st_z_out;
      st_stage_q <= k + 3'd1;
    end
  end

  assign bus.st_x     = st_x_q;
  assign bus.st_y     = st_y_q;
  assign bus.st_z     = st_z_q;
  assign bus.st_mode  = st_mode_q;
  assign bus.st_stage = st_stage_q;

  assign bus.out_valid = (state == DONE);
  assign bus.out_x     = wx;
  assign bus.out_y     = wy;
  assign bus.out_z     = wz;
  assign bus.out_mode  = wmode;
  assign bus.out_id    = wid;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler with a switchable stage model:
// a real vectoring/rotating CORDIC micro-rotation or a +1/+2/+3 pass-through.
module tb_cordic_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pass_mode = 1'b1;

  int n_cmp = 0;
  int n_mis = 0;
  int viol  = 0;
  int res_n = 0;
  logic        res_id [16];
  logic [15:0] res_x  [16];

  int atan_tab [8] = '{201, 119, 63, 32, 16, 8, 4, 2};

  cordic_scheduler_if bus ();

  cordic_scheduler #(.N_ITER(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic int sm2int(input logic [15:0] v);
    int m;
    m = int'(v[14:0]);
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] int2sm(input int a);
    logic [15:0] r;
    if (a < 0) r = {1'b1, 15'(-a)};
    else       r = {1'b0, 15'(a)};
    return r;
  endfunction

  // Stage model: registered, one-cycle latency.
  always @(posedge clock) begin : stage_model
    int xs, ys, zs, d, kk;
    if (pass_mode) begin
      bus.st_x_out <= bus.st_x + 16'd1;
      bus.st_y_out <= bus.st_y + 16'd2;
      bus.st_z_out <= bus.st_z + 16'd3;
    end else begin
      xs = sm2int(bus.st_x);
      ys = sm2int(bus.st_y);
      zs = sm2int(bus.st_z);
      kk = int'(bus.st_stage);
      if (bus.st_mode) begin
        d = (ys >= 0) ? 1 : -1;
        bus.st_x_out <= int2sm(xs + d * (ys >>> kk));
        bus.st_y_out <= int2sm(ys - d * (xs >>> kk));
        bus.st_z_out <= int2sm(zs + d * atan_tab[kk]);
      end else begin
        d = (zs >= 0) ? 1 : -1;
        bus.st_x_out <= int2sm(xs - d * (ys >>> kk));
        bus.st_y_out <= int2sm(ys + d * (xs >>> kk));
        bus.st_z_out <= int2sm(zs - d * atan_tab[kk]);
      end
    end
  end

  // Result log and protocol watch.
  always @(negedge clock) begin
    if (bus.out_valid && bus.out_ready && res_n < 16) begin
      res_id[res_n] <= bus.out_id;
      res_x[res_n]  <= bus.out_x;
      res_n         <= res_n + 1;
    end
    viol <= viol + int'(bus.r0_ready && bus.r1_ready)
                 + int'((bus.r0_ready || bus.r1_ready) && bus.out_valid);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int id);
    id = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (bus.r0_valid && bus.r0_ready) begin id = 0; break; end
      if (bus.r1_valid && bus.r1_ready) begin id = 1; break; end
    end
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (bus.out_valid) begin lat = c; break; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic set_r0(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z, input logic m);
    bus.r0_x = x; bus.r0_y = y; bus.r0_z = z; bus.r0_mode = m;
  endtask

  task automatic set_r1(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z, input logic m);
    bus.r1_x = x; bus.r1_y = y; bus.r1_z = z; bus.r1_mode = m;
  endtask

  initial begin
    int g, lat, zo;
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b0; bus.out_ready = 1'b1;
    set_r0(16'h0, 16'h0, 16'h0, 1'b0);
    set_r1(16'h0, 16'h0, 16'h0, 1'b0);

    // Reset state
    @(negedge clock);
    check_val("rst_r0_ready", bus.r0_ready, 0);
    @(negedge clock);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_st_stage", bus.st_stage, 0);
    check_val("rst_out_x", bus.out_x, 0);
    check_val("rst_out_id", bus.out_id, 0);
    check_val("rst_out_mode", bus.out_mode, 0);
    bus.r0_valid = 1'b0;
    #1 reset = 1'b0;

    // Single job through a real CORDIC stage: atan(1) in 8 fraction bits
    do_reset();
    pass_mode = 1'b0;
    set_r0(16'h0100, 16'h0100, 16'h0000, 1'b1);
    bus.r0_valid = 1'b1;
    wait_grant(g);
    check_val("single_grant", g, 0);
    @(posedge clock); #1 bus.r0_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clock);
      if (c % 2 == 1 && c <= 15) check_val("single_stage", bus.st_stage, (c - 1) / 2);
      if (c == 16) check_val("single_ov_early", bus.out_valid, 0);
      if (c == 17) check_val("single_ov_17", bus.out_valid, 1);
    end
    check_val("single_id", bus.out_id, 0);
    check_val("single_mode", bus.out_mode, 1);
    zo = sm2int(bus.out_z);
    check_val("single_atan_z", (zo >= 199 && zo <= 203), 1);
    @(negedge clock);
    check_val("single_idle", bus.out_valid, 0);

    // Contention from reset release, pass-through stage
    pass_mode = 1'b1;
    reset = 1'b1;
    set_r0(16'h0010, 16'h0020, 16'h0030, 1'b0);
    set_r1(16'h0041, 16'h0052, 16'h0063, 1'b1);
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    res_n = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    wait_grant(g);
    check_val("cont_first", g, 0);
    @(posedge clock); #1 bus.r0_valid = 1'b0;
    wait_grant(g);
    check_val("cont_second", g, 1);
    @(posedge clock); #1 bus.r1_valid = 1'b0;
    wait_out(lat);
    check_val("cont_lat", lat, 17);
    check_val("cont_x", bus.out_x, 16'h0049);
    check_val("cont_y", bus.out_y, 16'h0062);
    check_val("cont_z", bus.out_z, 16'h007B);
    check_val("cont_mode", bus.out_mode, 1);
    @(posedge clock); #1;
    check_val("cont_nres", res_n, 2);
    check_val("cont_id0", res_id[0], 0);
    check_val("cont_id1", res_id[1], 1);
    check_val("cont_x0", res_x[0], 16'h0018);

    // Fairness: both valid continuously for six jobs
    do_reset();
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_grant(g);
      check_val("fair_grant", g, i % 2);
    end
    @(posedge clock); #1 bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;

    // Backpressure in DONE
    do_reset();
    bus.out_ready = 1'b0;
    set_r0(16'h0100, 16'h0200, 16'h0300, 1'b0);
    set_r1(16'h0001, 16'h0002, 16'h0003, 1'b0);
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    wait_grant(g);
    check_val("bp_grant", g, 0);
    @(posedge clock); #1 bus.r0_valid = 1'b0;
    wait_out(lat);
    check_val("bp_lat", lat, 17);
    for (int i = 0; i < 5; i++) begin
      check_val("bp_x", bus.out_x, 16'h0108);
      check_val("bp_y", bus.out_y, 16'h0210);
      check_val("bp_z", bus.out_z, 16'h0318);
      check_val("bp_valid", bus.out_valid, 1);
      check_val("bp_readies", {bus.r0_ready, bus.r1_ready}, 0);
      @(negedge clock);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    check_val("bp_idle_ov", bus.out_valid, 0);
    check_val("bp_idle_r1", bus.r1_ready, 1);
    @(posedge clock); #1 bus.r1_valid = 1'b0;

    // Reset pulsed in cycle 8 of a job
    do_reset();
    set_r0(16'h0011, 16'h0022, 16'h0033, 1'b0);
    bus.r0_valid = 1'b1;
    wait_grant(g);
    check_val("mr_grant", g, 0);
    @(posedge clock); #1 bus.r0_valid = 1'b0;
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    set_r0(16'h0020, 16'h0040, 16'h0060, 1'b1);
    bus.r0_valid = 1'b1;
    @(negedge clock);
    check_val("mr_stage_c8", bus.st_stage, 3);
    check_val("mr_rst_ready", bus.r0_ready, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_val("mr_stage_clr", bus.st_stage, 0);
    check_val("mr_st_x_clr", bus.st_x, 0);
    check_val("mr_out_x_clr", bus.out_x, 0);
    check_val("mr_ov", bus.out_valid, 0);
    check_val("mr_regrant", bus.r0_ready, 1);
    @(posedge clock); #1 bus.r0_valid = 1'b0;
    wait_out(lat);
    check_val("mr_lat", lat, 17);
    check_val("mr_x", bus.out_x, 16'h0028);
    check_val("mr_y", bus.out_y, 16'h0050);
    check_val("mr_z", bus.out_z, 16'h0078);
    @(posedge clock); #1;

    check_val("protocol_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 SHALL have parameter N_ITER, default 8, the number of stage iterations per job (legal 1..8).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port r0_valid  input  1  requester 0 job offered.
REQ-005 SHALL have port r0_ready  output  1  requester 0 job accepted this cycle when r0_valid is also high.
REQ-006 SHALL have port r0_x / r0_y / r0_z  input  16 each  requester 0 operands, sign-magnitude (bit 15 sign, 7 integer bits, 8 fraction bits).
REQ-007 SHALL have port r0_mode  input  1  0 = rotate, 1 = phase_calc.
REQ-008 SHALL have ports r1_valid, r1_ready, r1_x, r1_y, r1_z, r1_mode, with identical direction, width and meaning for requester 1.
REQ-009 SHALL have port st_x / st_y / st_z  output  16 each  operands driven to the shared CORDIC stage.
REQ-010 SHALL have port st_mode  output  1  mode driven to the stage.
REQ-011 SHALL have port st_stage  output  3  iteration index driven to the stage.
REQ-012 SHALL have port st_x_out / st_y_out / st_z_out  input  16 each  stage results, registered by the stage with one-cycle latency.
REQ-013 SHALL have port out_valid  output  1  result available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port out_x / out_y / out_z  output  16 each  final x, y and z.
REQ-016 SHALL have port out_mode  output  1  mode of the completed job.
REQ-017 SHALL have port out_id  output  1  requester (0/1) that owns the result.

Function
REQ-018 SHALL implement an FSM with four states, IDLE, ISSUE, CAPTURE and DONE, plus an iteration counter k (3 bits) and working registers wx, wy, wz, wmode and wid.
REQ-019 IDLE: SHALL assert at most one of r0_ready or r1_ready, and only when the matching valid is high (combinational grant).
REQ-020 Arbitration: SHALL be round-robin using a last-served pointer. When both requesters are valid, the one not last served is granted. A single valid requester is always granted.
REQ-021 On an accept (valid & ready): SHALL load the working registers from the granted requester, set k=0, update the pointer and go to ISSUE.
REQ-022 ISSUE: SHALL drive st_x/st_y/st_z/st_mode from the working registers and st_stage = k, then go to CAPTURE.
REQ-023 CAPTURE: SHALL load wx/wy/wz from st_*_out. If k = N_ITER-1 it SHALL go to DONE; otherwise k increments and the FSM returns to ISSUE.
REQ-024 In IDLE and DONE, st_* outputs SHALL hold their last values; st_stage changes only in ISSUE.
REQ-025 The scheduler SHALL perform no arithmetic on operands; values pass through bit-exact.
REQ-026 Latency: with the acceptance cycle as cycle 0, out_valid SHALL first be high in cycle 2*N_ITER+1 (cycle 17 for the default).
REQ-027 DONE: SHALL assert out_valid and present out_* from the working registers, stable until out_ready is high. On out_valid & out_ready it SHALL go to IDLE.
REQ-028 r0_ready and r1_ready SHALL be low in every state except IDLE; no new job is accepted in the same cycle as a result handshake.
REQ-029 Requests that are valid while busy SHALL stay pending (no drop); the requester holds its operands until granted.

Reset
REQ-030 With reset high at a clock edge, the block SHALL go to IDLE with k=0, last-served pointer = 1 (requester 0 wins first), and out_valid=0.
REQ-031 With reset high at a clock edge, all working, st_* and out_* registers SHALL be cleared to 0, and out_id=0 and out_mode=0.
REQ-032 Reset asserted mid-job SHALL abort the job: no out_valid is produced and st_stage returns to 0.
REQ-033 r0_ready and r1_ready SHALL be low during any cycle in which reset is high.

Verification
REQ-034 Single job: r0 offers x=0x0100, y=0x0100, z=0x0000, mode=1 with a real stage attached -> st_stage sequence 0..7, out_valid at cycle 17, out_z within 2 LSB of 0x00C9, out_id=0.
REQ-035 Contention: r0 and r1 both valid from reset release -> r0 granted first, r1 granted on the next IDLE, and out_id sequence 0,1.
REQ-036 Fairness: both valid continuously for 6 jobs -> grants alternate 0,1,0,1,0,1.
REQ-037 Backpressure: out_ready held low for 5 cycles in DONE -> out_* stable, both readies low, and return to IDLE the cycle after out_ready rises.
REQ-038 Reset mid-job: reset pulsed in cycle 8 of a job -> no out_valid, outputs cleared, and the next job completes normally with 17-cycle latency.
REQ-039 Pass-through: with a stage model that returns x+1, y+2, z+3 -> after 8 iterations out_x/out_y/out_z equal the input +8/+16/+24 exactly.
